pacman_input_ctrl: RTL and testbench
====================================

# pacman_input_ctrl

Input conditioning stage between `hps_io` (keyboard events, merged joystick word) and the `pacman` core's `in0`/`in1` ports.
- Decodes PS/2 key events into held-key flags and merges them with the joystick word.
- Applies orientation rotation and a 4-way last-pressed arbitration per player.
- Stretches coin presses to a whole number of frames so the game's once-per-vblank sampling never misses a credit.
- Drives the core's active-low `in0`/`in1` input registers.

## Interface
Parameters:
- COIN_FRAMES, 3: number of vblank rising edges a coin bit is held asserted per press (1..15).

Ports:
- clk  in  1  system clock (clk_sys).
- reset  in  1  synchronous, active-high reset.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8:0] scancode (bit 8 = extended).
- joy  in  16  merged joystick: [0] right, [1] left, [2] down, [3] up, [4] skip, [5] start1, [6] start2, [7] coin.
- rotate  in  1  1 = horizontal orientation; remaps directions.
- cabinet  in  1  1 = cocktail.
- vblank  in  1  core vertical blank.
- in0  out  8  active-low: [3:0] P1 up/left/right/down, [4] rack skip, [5] coin1, [6] coin2, [7] service (always 1).
- in1  out  8  active-low: [3:0] P2 up/left/right/down, [4] test (always 1), [5] start1, [6] start2, [7] ~cabinet.

## Operation
Key decode:
- A change of ps2_key[10] versus its registered copy is an event; the event writes ps2_key[9] into the matching flag.
- Arrows match on code[7:0] with any bit 8: 75 up, 72 down, 6B left, 74 right.
- Exact 9-bit codes:
  - P1: 029/014 skip, 005 start1, 006 start2, 004 coin1, 003 skip.
  - Keypad-style: 016 start1, 01E start2, 02E coin1, 036 coin2.
  - P2: 02D up, 02B down, 023 left, 034 right, 01C skip.
- Unlisted codes are ignored.

Direction requests:
- P1 = arrow flags | joy[3:0]; P2 = P2 flags | joy[3:0].
- The request is formed as vector {up,down,left,right}.
- When rotate=1 the vector becomes {left,right,down,up} (each field from the named source).

4-way arbiter, one per player:
- Stage A registers the request; stage B registers stage A.
- new = A & ~B.
- On any new bit, mask becomes one-hot of that bit. With simultaneous new bits, precedence is up > down > left > right.
- Output = A & mask. The mask persists after release (mask resets to 0).

Buttons:
- skip = skip flags | joy[4].
- start1 = flags | joy[5]; start2 = flags | joy[6].

Coin stretcher, per slot (coin1 = flags | joy[7]; coin2 = flag):
- States IDLE → ACTIVE → WAIT_REL → IDLE.
- IDLE: a rising edge of the request enters ACTIVE with count=0. The coin bit is asserted from ACTIVE entry.
- ACTIVE: each vblank rising edge increments count. At count = COIN_FRAMES, go to WAIT_REL and deassert.
- A vblank edge in the same cycle as ACTIVE entry is not counted.
- WAIT_REL: return to IDLE when the request is low. Presses during ACTIVE/WAIT_REL are ignored, so holding gives exactly one credit.

Outputs:
- in0/in1 are registered and bitwise-inverted.
- in1[7] = ~cabinet, registered.

## Timing
- Reset values:
  - in0 = 8'hFF, in1 = 8'hFF.
  - All flags 0, masks 0, coin FSMs IDLE, count 0.
  - The toggle copy loads ps2_key[10] during reset, so there is no phantom event after reset.
- Latency:
  - joy direction change → in0/in1: 3 clk (A, B/mask, output register).
  - ps2 event → flag: 1 clk. Key direction → output: 4 clk.
  - Buttons and coin assertion: joy → output 2 clk; key → output 3 clk.
- Coin pulse width: from first assertion to the COIN_FRAMES-th vblank rising edge, plus 1 clk output register.
- Reset mid-pulse: the coin bit returns to 1 on the cycle after reset is sampled.
- Rotate change mid-hold: treated as a new request edge on the remapped bit, so the mask follows it.

## Structure
- pacman_input_pkg holds:
  - scancode localparams;
  - joy bit indices;
  - in0/in1 bit positions;
  - coin FSM state enum.
- One sub-module, four_way_arb (clk, reset, req[3:0], dir[3:0]), is instantiated twice.
- The coin stretcher stays inline as two instances of a generate loop.

## Test plan
- Reset, no input → in0=FF, in1=FF. With cabinet=1 after reset → in1=7F.
- joy[3] (up) held, then joy[1] (left) added → in0[3:0]: up low (E) after 3 clk, then left only low after 3 more clk. Release left → all high, mask kept at left.
- joy[3] and joy[0] rise in the same cycle → only up asserted (in0[3:0]=E). With rotate=1, joy[3] (up) drives the right field (in0[3:0]=B).
- ps2_key event code 0x02E pressed, held 10 frames, COIN_FRAMES=3 → in0[5] low for exactly 3 vblank edges, then high. Release and re-press → one more 3-frame pulse.
- Coin pulse active, reset asserted after 1 frame → in0[5]=1 next clk. No event triggered by a stale ps2_key[10] after reset.
- Extended 0x175 pressed then released via two toggles → P1 up asserted, then cleared. Code 0x0FF → no output change.

Source files
------------

// File: rtl/pacman_input_pkg.sv
// Shared constants for the pacman input conditioning stage.
// Scancodes, joy/in0/in1 bit indices, flag slots, coin FSM states.
package pacman_input_pkg;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [8:0] SC_SKIP_A  = 9'h029;
  localparam logic [8:0] SC_SKIP_B  = 9'h014;
  localparam logic [8:0] SC_SKIP_C  = 9'h003;
  localparam logic [8:0] SC_START1  = 9'h005;
  localparam logic [8:0] SC_START2  = 9'h006;
  localparam logic [8:0] SC_COIN1   = 9'h004;
  localparam logic [8:0] SC_KSTART1 = 9'h016;
  localparam logic [8:0] SC_KSTART2 = 9'h01E;
  localparam logic [8:0] SC_KCOIN1  = 9'h02E;
  localparam logic [8:0] SC_KCOIN2  = 9'h036;
  localparam logic [8:0] SC_P2_UP   = 9'h02D;
  localparam logic [8:0] SC_P2_DOWN = 9'h02B;
  localparam logic [8:0] SC_P2_LEFT = 9'h023;
  localparam logic [8:0] SC_P2_RGT  = 9'h034;
  localparam logic [8:0] SC_P2_SKIP = 9'h01C;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_SKIP   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;
  localparam int JOY_COIN   = 7;

  localparam int F_P1_U   = 0;
  localparam int F_P1_D   = 1;
  localparam int F_P1_L   = 2;
  localparam int F_P1_R   = 3;
  localparam int F_P2_U   = 4;
  localparam int F_P2_D   = 5;
  localparam int F_P2_L   = 6;
  localparam int F_P2_R   = 7;
  localparam int F_SKIP   = 8;
  localparam int F_START1 = 9;
  localparam int F_START2 = 10;
  localparam int F_COIN1  = 11;
  localparam int F_COIN2  = 12;
  localparam int NFLAGS   = 13;

  localparam int IN_UP      = 0;
  localparam int IN_LEFT    = 1;
  localparam int IN_RIGHT   = 2;
  localparam int IN_DOWN    = 3;
  localparam int IN0_SKIP   = 4;
  localparam int IN0_COIN1  = 5;
  localparam int IN0_COIN2  = 6;
  localparam int IN0_SVC    = 7;
  localparam int IN1_TEST   = 4;
  localparam int IN1_START1 = 5;
  localparam int IN1_START2 = 6;
  localparam int IN1_CAB    = 7;

  typedef enum logic [1:0] {
    COIN_IDLE,
    COIN_ACTIVE,
    COIN_WAIT_REL
  } coin_state_e;

  // Request vector is {up,down,left,right}; rotation
  // re-sources it as {left,right,down,up}.
  function automatic logic [3:0] dir_req(
    input logic u, input logic d,
    input logic l, input logic r,
    input logic rot
  );
    return rot ? {l, r, d, u} : {u, d, l, r};
  endfunction

endpackage

// File: rtl/pacman_input_ctrl_if.sv
// Bundle between hps_io side and the pacman core inputs.
// slave: ps2/joy/rotate/cabinet/vblank in, in0/in1 out.
interface pacman_input_ctrl_if;
  logic [10:0] ps2_key;
  logic [15:0] joy;
  logic        rotate;
  logic        cabinet;
  logic        vblank;
  logic [7:0]  in0;
  logic [7:0]  in1;

  modport master (
    output ps2_key, joy, rotate,
    output cabinet, vblank,
    input  in0, in1
  );

  modport slave (
    input  ps2_key, joy, rotate,
    input  cabinet, vblank,
    output in0, in1
  );
endinterface

// File: rtl/four_way_arb.sv
// Last-pressed 4-way arbiter; req/dir are {up,down,left,right}.
// Ports: clk, reset, req[3:0] in, dir[3:0] out.
module four_way_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] dir
);
  logic [3:0] a_q, b_q, mask_q, mask_d, nw;

  assign nw  = a_q & ~b_q;
  assign dir = a_q & mask_q;

  always_comb begin
    mask_d = mask_q;
    priority case (1'b1)
      nw[3]:   mask_d = 4'b1000;
      nw[2]:   mask_d = 4'b0100;
      nw[1]:   mask_d = 4'b0010;
      nw[0]:   mask_d = 4'b0001;
      default: mask_d = mask_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      mask_q <= '0;
    end else begin
      a_q    <= req;
      b_q    <= a_q;
      mask_q <= mask_d;
    end
  end
endmodule

// File: rtl/pacman_input_ctrl.sv
// PS/2 + joystick conditioning into pacman in0/in1 (active low).
// Ports: clk, reset, bus (slave): ps2_key, joy, rotate, cabinet, vblank, in0, in1.
module pacman_input_ctrl
  import pacman_input_pkg::*;
#(
  parameter int COIN_FRAMES = 3
) (
  input  logic                clk,
  input  logic                reset,
  pacman_input_ctrl_if.slave  bus
);
  localparam logic [3:0] CF = 4'(COIN_FRAMES);

  logic              tog_q, tog_d;
  logic [NFLAGS-1:0] flg_q, flg_d;
  logic [8:0]        code;
  logic              pr;
  logic [3:0]        req1, req2, dir1, dir2;
  logic [2:0]        btn_q, btn_d;
  logic [1:0]        coin_req, coin_on;
  logic              vb_q, vb_rise;
  logic [7:0]        in0_q, in0_d, in1_q, in1_d;
  logic              unused_joy;

  assign unused_joy = ^bus.joy[15:8];
  assign code = bus.ps2_key[8:0];
  assign pr   = bus.ps2_key[9];

  always_comb begin
    tog_d = bus.ps2_key[10];
    flg_d = flg_q;
    if (bus.ps2_key[10] != tog_q) begin
      if (code[7:0] == SC_UP)         flg_d[F_P1_U] = pr;
      else if (code[7:0] == SC_DOWN)  flg_d[F_P1_D] = pr;
      else if (code[7:0] == SC_LEFT)  flg_d[F_P1_L] = pr;
      else if (code[7:0] == SC_RIGHT) flg_d[F_P1_R] = pr;
      else begin
        case (code)
          SC_SKIP_A, SC_SKIP_B,
          SC_SKIP_C, SC_P2_SKIP:   flg_d[F_SKIP]   = pr;
          SC_START1, SC_KSTART1:   flg_d[F_START1] = pr;
          SC_START2, SC_KSTART2:   flg_d[F_START2] = pr;
          SC_COIN1, SC_KCOIN1:     flg_d[F_COIN1]  = pr;
          SC_KCOIN2:               flg_d[F_COIN2]  = pr;
          SC_P2_UP:                flg_d[F_P2_U]   = pr;
          SC_P2_DOWN:              flg_d[F_P2_D]   = pr;
          SC_P2_LEFT:              flg_d[F_P2_L]   = pr;
          SC_P2_RGT:               flg_d[F_P2_R]   = pr;
          default:                 flg_d = flg_q;
        endcase
      end
    end
  end

  assign req1 = dir_req(
    flg_q[F_P1_U] | bus.joy[JOY_UP],
    flg_q[F_P1_D] | bus.joy[JOY_DOWN],
    flg_q[F_P1_L] | bus.joy[JOY_LEFT],
    flg_q[F_P1_R] | bus.joy[JOY_RIGHT],
    bus.rotate);

  assign req2 = dir_req(
    flg_q[F_P2_U] | bus.joy[JOY_UP],
    flg_q[F_P2_D] | bus.joy[JOY_DOWN],
    flg_q[F_P2_L] | bus.joy[JOY_LEFT],
    flg_q[F_P2_R] | bus.joy[JOY_RIGHT],
    bus.rotate);

  four_way_arb u_arb1 (
    .clk   (clk),
    .reset (reset),
    .req   (req1),
    .dir   (dir1)
  );

  four_way_arb u_arb2 (
    .clk   (clk),
    .reset (reset),
    .req   (req2),
    .dir   (dir2)
  );

  // btn_q = {start2, start1, skip}
  assign btn_d = {
    flg_q[F_START2] | bus.joy[JOY_START2],
    flg_q[F_START1] | bus.joy[JOY_START1],
    flg_q[F_SKIP]   | bus.joy[JOY_SKIP]};

  assign coin_req = {
    flg_q[F_COIN2],
    flg_q[F_COIN1] | bus.joy[JOY_COIN]};

  assign vb_rise = bus.vblank & ~vb_q;

  for (genvar g = 0; g < 2; g++) begin : g_coin
    coin_state_e st_q, st_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rq_q;

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      unique case (st_q)
        COIN_IDLE: begin
          if (coin_req[g] & ~rq_q) begin
            st_d  = COIN_ACTIVE;
            cnt_d = 4'd0;
          end
        end
        COIN_ACTIVE: begin
          if (vb_rise) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == CF) st_d = COIN_WAIT_REL;
          end
        end
        COIN_WAIT_REL: begin
          if (!coin_req[g]) st_d = COIN_IDLE;
        end
        default: st_d = COIN_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        st_q  <= COIN_IDLE;
        cnt_q <= 4'd0;
        rq_q  <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        rq_q  <= coin_req[g];
      end
    end

    assign coin_on[g] = (st_q == COIN_ACTIVE);
  end

  assign in0_d = ~{1'b0, coin_on[1], coin_on[0], btn_q[0],
                   dir1[2], dir1[0], dir1[1], dir1[3]};

  assign in1_d = {~bus.cabinet, ~btn_q[2], ~btn_q[1], 1'b1,
                  ~dir2[2], ~dir2[0], ~dir2[1], ~dir2[3]};

  always_ff @(posedge clk) begin
    tog_q <= tog_d;
    if (reset) begin
      flg_q <= '0;
      btn_q <= '0;
      vb_q  <= 1'b0;
      in0_q <= 8'hFF;
      in1_q <= 8'hFF;
    end else begin
      flg_q <= flg_d;
      btn_q <= btn_d;
      vb_q  <= bus.vblank;
      in0_q <= in0_d;
      in1_q <= in1_d;
    end
  end

  assign bus.in0 = in0_q;
  assign bus.in1 = in1_q;
endmodule

// File: tb/tb_pacman_input_ctrl.sv
// Directed bench for pacman_input_ctrl.
// Drives the interface master side and checks in0/in1.
module tb_pacman_input_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pacman_input_ctrl_if bus_if ();

  pacman_input_ctrl #(.COIN_FRAMES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_key(input logic [8:0] c, input logic p);
    bus_if.ps2_key = {~bus_if.ps2_key[10], p, c};
  endtask

  task automatic chk0(input string nm, input logic [7:0] exp);
    checks++;
    if (bus_if.in0 !== exp) begin
      errors++;
      $display("FAIL %s: in0=%h expected %h", nm, bus_if.in0, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic [7:0] exp);
    checks++;
    if (bus_if.in1 !== exp) begin
      errors++;
      $display("FAIL %s: in1=%h expected %h", nm, bus_if.in1, exp);
    end
  endtask

  task automatic frame();
    bus_if.vblank = 1'b1;
    tick();
    bus_if.vblank = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    chk0("reset_in0", 8'hFF);
    chk1("reset_in1", 8'hFF);
    bus_if.cabinet = 1'b1;
    tick();
    chk1("cabinet_in1", 8'h7F);
    bus_if.cabinet = 1'b0;
    tick();
    chk1("cabinet_off_in1", 8'hFF);
  endtask

  task automatic test_joy_dirs();
    bus_if.joy = 16'h0008;
    tick(2);
    chk0("up_lat2", 8'hFF);
    tick();
    chk0("up_lat3", 8'hFE);
    chk1("up_p2", 8'hFE);
    bus_if.joy = 16'h000A;
    tick(2);
    chk0("left_add_lat2", 8'hFE);
    tick();
    chk0("left_wins", 8'hFD);
    bus_if.joy = 16'h0008;
    tick(3);
    chk0("left_release", 8'hFF);
    bus_if.joy = 16'h0000;
    tick(3);
  endtask

  task automatic test_simul_rotate();
    bus_if.joy = 16'h0009;
    tick(3);
    chk0("up_right_same", 8'hFE);
    bus_if.joy = 16'h0000;
    tick(3);
    bus_if.rotate = 1'b1;
    bus_if.joy = 16'h0008;
    tick(3);
    chk0("rot_up_right", 8'hFB);
    bus_if.joy = 16'h0000;
    tick(3);
    bus_if.rotate = 1'b0;
    tick(3);
  endtask

  task automatic test_buttons();
    bus_if.joy = 16'h0020;
    tick();
    chk1("start1_lat1", 8'hFF);
    tick();
    chk1("start1_lat2", 8'hDF);
    bus_if.joy = 16'h0010;
    tick(2);
    chk0("skip_joy", 8'hEF);
    bus_if.joy = 16'h0000;
    tick(2);
  endtask

  task automatic test_coin_stretch();
    send_key(9'h02E, 1'b1);
    tick(2);
    chk0("coin_lat2", 8'hFF);
    tick();
    chk0("coin_lat3", 8'hDF);
    for (int f = 0; f < 3; f++) begin
      chk0($sformatf("coin_low_f%0d", f), 8'hDF);
      frame();
    end
    chk0("coin_end", 8'hFF);
    for (int f = 3; f < 10; f++) frame();
    chk0("coin_held", 8'hFF);
    send_key(9'h02E, 1'b0);
    tick(4);
    send_key(9'h02E, 1'b1);
    tick(3);
    chk0("coin2_start", 8'hDF);
    for (int f = 0; f < 3; f++) frame();
    chk0("coin2_end", 8'hFF);
    send_key(9'h02E, 1'b0);
    tick(4);
  endtask

  task automatic test_reset_mid_pulse();
    send_key(9'h02E, 1'b1);
    tick(3);
    chk0("mid_start", 8'hDF);
    frame();
    reset = 1'b1;
    send_key(9'h175, 1'b1);
    tick();
    chk0("mid_reset", 8'hFF);
    tick();
    reset = 1'b0;
    tick(5);
    chk0("no_phantom", 8'hFF);
  endtask

  task automatic test_key_decode();
    send_key(9'h175, 1'b1);
    tick(3);
    chk0("ext_up_lat3", 8'hFF);
    tick();
    chk0("ext_up_lat4", 8'hFE);
    send_key(9'h175, 1'b0);
    tick(4);
    chk0("ext_up_rel", 8'hFF);
    send_key(9'h0FF, 1'b1);
    tick(5);
    chk0("unlisted_in0", 8'hFF);
    chk1("unlisted_in1", 8'hFF);
    send_key(9'h02D, 1'b1);
    tick(4);
    chk1("p2_up_key", 8'hFE);
    chk0("p2_up_p1", 8'hFF);
    send_key(9'h02D, 1'b0);
    tick(4);
    chk1("p2_up_rel", 8'hFF);
  endtask

  initial begin
    reset = 1'b1;
    bus_if.ps2_key = '0;
    bus_if.joy     = '0;
    bus_if.rotate  = 1'b0;
    bus_if.cabinet = 1'b0;
    bus_if.vblank  = 1'b0;
    test_reset();
    test_joy_dirs();
    test_simul_rotate();
    test_buttons();
    test_coin_stretch();
    test_reset_mid_pulse();
    test_key_decode();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
